pin_debounce_conditioner: RTL

Conditions up to 16 asynchronous board-level input pins (buttons, switches, hands-free control lines) into a clean, registered 32-bit status word. The word drives the `in_port` of the 32-bit Avalon input PIO slave that the Nios II software polls. Each pin is:
- synchronized to `clk`;
- debounced against a prescaled sample tick;
- summarized as a stable level plus a wrapping change counter, so software can detect activity between polls.

---
 rtl/pin_debounce_conditioner.sv | 116 +++++++++++
 1 files changed

// File: rtl/pin_debounce_conditioner.sv
// Synchronizes, debounces and summarizes up to 16 board pins into a 32-bit PIO status word.
// Optional build macro PIN_DEB_TIMESTAMP_EN adds an 8-bit tick timestamp of the last change in out_port[31:24].
module pin_debounce_conditioner #(
    parameter int WIDTH          = 16,
    parameter int PRESCALE       = 50000,
    parameter int STABLE_SAMPLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] pin_in,
    output logic [31:0]      out_port
);

    localparam int               PRE_W    = $clog2(PRESCALE);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [3:0]       CNT_LAST = 4'(STABLE_SAMPLES - 1);

    logic [WIDTH-1:0]      sync1_q;
    logic [WIDTH-1:0]      sync2_q;
    logic [PRE_W-1:0]      pre_cnt_q;
    logic [PRE_W-1:0]      pre_cnt_d;
    logic                  tick;
    logic [WIDTH-1:0]      stable_q;
    logic [WIDTH-1:0]      stable_d;
    logic [WIDTH-1:0][3:0] cnt_q;
    logic [WIDTH-1:0][3:0] cnt_d;
    logic [7:0]            chg_cnt_q;
    logic [7:0]            chg_cnt_d;
    logic                  changed;
    logic [15:0]           stable_ext;
    logic [7:0]            ts_field;
    logic [31:0]           out_port_q;
    logic [31:0]           out_port_d;

    assign tick = (pre_cnt_q == PRE_LAST);

    always_comb begin
        pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        stable_d  = stable_q;
        cnt_d     = cnt_q;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                // Any sample agreeing with the accepted level restarts qualification.
                if (sync2_q[i] == stable_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2_q[i];
                    cnt_d[i]    = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
        changed   = (stable_d != stable_q);
        chg_cnt_d = changed ? chg_cnt_q + 8'd1 : chg_cnt_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            pre_cnt_q <= '0;
            stable_q  <= '0;
            cnt_q     <= '0;
            chg_cnt_q <= '0;
        end else begin
            sync1_q   <= pin_in;
            sync2_q   <= sync1_q;
            pre_cnt_q <= pre_cnt_d;
            stable_q  <= stable_d;
            cnt_q     <= cnt_d;
            chg_cnt_q <= chg_cnt_d;
        end
    end

`ifdef PIN_DEB_TIMESTAMP_EN
    logic [7:0] tick_cnt_q;
    logic [7:0] ts_latch_q;

    // The latch takes the tick count before this tick's increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_q <= '0;
            ts_latch_q <= '0;
        end else begin
            if (tick) begin
                tick_cnt_q <= tick_cnt_q + 8'd1;
            end
            if (changed) begin
                ts_latch_q <= tick_cnt_q;
            end
        end
    end

    assign ts_field = ts_latch_q;
`else
    assign ts_field = 8'h00;
`endif

    always_comb begin
        stable_ext               = '0;
        stable_ext[WIDTH-1:0]    = stable_q;
        out_port_d               = {ts_field, chg_cnt_q, stable_ext};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_port_q <= '0;
        end else begin
            out_port_q <= out_port_d;
        end
    end

    assign out_port = out_port_q;

endmodule
